// File: rtl/score_frame_tx.sv
// Serial transmitter for the score link: frames {sync, score hi, score lo, rnd, chk}
// as back-to-back 8N1 bytes on a single idle-high line.
module score_frame_tx #(
    parameter int          CLKS_PER_BIT = 4,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] score,
    input  logic [7:0]  rnd,
    input  logic        send,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [2:0]    byte_idx;
    logic [31:0]   payload;   // {score hi, score lo, rnd, chk}, frozen for the whole frame
    logic [7:0]    cur_byte;
    logic          baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);

    always_comb begin
        cur_byte = SYNC_BYTE;
        case (byte_idx)
            3'd1:    cur_byte = payload[31:24];
            3'd2:    cur_byte = payload[23:16];
            3'd3:    cur_byte = payload[15:8];
            3'd4:    cur_byte = payload[7:0];
            default: cur_byte = SYNC_BYTE;
        endcase
    end

    // NOTE: every register here updates with <= so all reads in this block see
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            payload  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (send) begin
                        payload  <= {score, rnd, score[15:8] ^ score[7:0] ^ rnd};
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx       <= cur_byte[0];
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (byte_idx == 3'd4) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= START;
                            tx       <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_frame_tx.sv
// Randomized scoreboard bench for score_frame_tx: a frame-level model predicts
// bytes, busy and done; a UART decoder and a per-cycle monitor check the line.
module tb_score_frame_tx;

    localparam int C     = 4;
    localparam int FRAME = 50 * C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        send = 1'b0;
    logic [15:0] score = '0;
    logic [7:0]  rnd = '0;
    logic        tx, busy, done;

    int tests = 0;
    int fails = 0;

    // Model state: bytes still owed, cycles of busy remaining, expected done.
    logic [7:0] exp_q[$];
    int         rem = 0;
    bit         exp_done = 1'b0;
    int         done_seen = 0;

    score_frame_tx #(.CLKS_PER_BIT(C), .SYNC_BYTE(8'hA5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .score(score),
        .rnd  (rnd),
        .send (send),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Frame-level model: an accepted request owes 5 bytes and 50*C busy cycles.
    initial begin
        logic [7:0] chk;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                rem      = 0;
                exp_done = 1'b0;
                exp_q.delete();
            end else begin
                exp_done = 1'b0;
                if (rem > 0) begin
                    rem--;
                    if (rem == 0) exp_done = 1'b1;
                end else if (send) begin
                    rem = FRAME;
                    chk = score[15:8] ^ score[7:0] ^ rnd;
                    exp_q.push_back(8'hA5);
                    exp_q.push_back(score[15:8]);
                    exp_q.push_back(score[7:0]);
                    exp_q.push_back(rnd);
                    exp_q.push_back(chk);
                end
            end
        end
    end

    // Per-cycle monitor on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset tx", tx, 1);
                check("reset busy", busy, 0);
                check("reset done", done, 0);
            end else begin
                check("busy", busy, (rem > 0) ? 1 : 0);
                check("done", done, exp_done);
                if (rem == 0) check("idle tx", tx, 1);
                if (done) done_seen++;
            end
        end
    end

    task automatic skip(input int n, output bit ab);
        ab = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (!rst_n) ab = 1'b1;
        end
    endtask

    // UART decoder: samples each bit at its centre and pops the scoreboard.
    initial begin
        logic [7:0] b;
        logic       stop_bit;
        logic [7:0] want;
        bit         ab, any_ab;
        forever begin
            @(negedge clk);
            if (rst_n && tx == 1'b0) begin
                skip(C + C / 2, ab);
                any_ab = ab;
                b[0] = tx;
                for (int i = 1; i < 8; i++) begin
                    skip(C, ab);
                    any_ab |= ab;
                    b[i] = tx;
                end
                skip(C, ab);
                any_ab |= ab;
                stop_bit = tx;
                if (!any_ab) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected byte", {24'd0, b}, 32'hFFFF_FFFF);
                    end else begin
                        want = exp_q.pop_front();
                        check("byte", b, want);
                    end
                    check("stop bit", stop_bit, 1);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_send();
        send = 1'b1;
        tick(1);
        send = 1'b0;
    endtask

    task automatic wait_idle();
        int budget = 4 * FRAME;
        while (rem > 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        if (rem > 0) check("idle timeout", 0, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, cnt, budget;

        // Reset and idle
        rst_n = 1'b0;
        tick(5);
        rst_n = 1'b1;
        tick(100);

        // Basic frame: A5 12 34 5A 7C
        score = 16'h1234;
        rnd   = 8'h5A;
        d0 = done_seen;
        pulse_send();
        wait_idle();
        tick(3);
        check("basic done count", done_seen - d0, 1);
        check("basic drained", exp_q.size(), 0);

        // Input stability: inputs change during byte 1
        score = 16'hFFFF;
        rnd   = 8'h00;
        pulse_send();
        tick(15 * C);
        score = 16'h0000;
        rnd   = 8'hFF;
        wait_idle();
        tick(3);

        // Send while busy at cycles 10, 100, 199
        score = 16'(($urandom));
        rnd   = 8'($urandom);
        d0 = done_seen;
        pulse_send();
        tick(9);   pulse_send();
        tick(89);  pulse_send();
        tick(98);  pulse_send();
        wait_idle();
        tick(10);
        check("busy-send done count", done_seen - d0, 1);
        check("busy-send drained", exp_q.size(), 0);

        // Continuous send: three back-to-back frames
        score = 16'h0001;
        rnd   = 8'h01;
        send  = 1'b1;
        cnt = 0;
        budget = 4 * (FRAME + 1);
        while (cnt < 3 && budget > 0) begin
            tick(1);
            if (done) cnt++;
            budget--;
        end
        send = 1'b0;
        check("continuous done count", cnt, 3);
        wait_idle();
        tick(10);

        // Reset during byte 2
        score = 16'(($urandom));
        rnd   = 8'($urandom);
        d0 = done_seen;
        pulse_send();
        tick(25 * C);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort tx", tx, 1);
        check("abort busy", busy, 0);
        tick(3);
        rst_n = 1'b1;
        tick(20 * C);
        check("abort no done", done_seen - d0, 0);
        score = 16'hBEEF;
        rnd   = 8'h42;
        pulse_send();
        wait_idle();
        tick(5);

        // Randomized frames with stray requests mid-frame
        for (int f = 0; f < 20; f++) begin
            score = 16'($urandom);
            rnd   = 8'($urandom);
            pulse_send();
            tick($urandom_range(1, 60));
            score = 16'($urandom);
            rnd   = 8'($urandom);
            if ($urandom_range(0, 1) == 1) pulse_send();
            wait_idle();
            tick($urandom_range(0, 5));
        end

        tick(12 * C);
        check("final drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
